fx_match_pipe: RTL and testbench
================================

Name: fx_match_pipe

Overview:
Parametrised, pipelined fixed-point format converter: signed two's-complement input (IW bits, IF fractional) to output (OW bits, OF fractional).
- Quantisation: truncate, round-half-up or convergent rounding, selected per instance.
- Overflow: wrap or saturate.
- Pipeline: registered stages with a valid qualifier, a configurable trailing delay line, a sticky overflow flag and a saturating overflow event counter.
- Sits between datapath stages wherever a word-length change is needed; it is the streaming successor of the combinational format matchers.

Parameters:
IW, 14, input word width (2..32)
IF, 6, input fractional bits (0..IW-1)
OW, 12, output word width (2..32)
OF, 4, output fractional bits (0..OW-1)
QUAN_MODE, 1, 0 = truncate (floor), 1 = round-half-up, 2 = convergent (half-to-even)
OVF_MODE, 1, 0 = wrap, 1 = saturate
EXTRA_DELAY, 0, additional register stages after the overflow stage (0..16)
CNTW, 8, overflow counter width

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  input sample qualifier
i_data  in  IW  signed input sample
i_clr_ovf  in  1  clears o_ovf_sticky and o_ovf_cnt
o_valid  out  1  output sample qualifier
o_data  out  OW  signed converted sample
o_ovf  out  1  overflow occurred on the sample currently on o_data
o_ovf_sticky  out  1  set by any overflow since last clear/reset
o_ovf_cnt  out  CNTW  count of overflowed valid samples, saturating

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all pipeline registers, o_valid, o_data, o_ovf, o_ovf_sticky and o_ovf_cnt go to 0. Reset mid-stream discards all in-flight samples; no stale o_valid is emitted afterwards.
- Streaming, no backpressure. Data registers load only when their stage valid is 1; o_data holds its last value while o_valid=0.
- Latency: 2 + EXTRA_DELAY cycles from i_valid to o_valid. Full throughput, one sample per cycle.
- Stage 1, quantisation. Let S = IF - OF.
  - S <= 0: left-shift by -S, exact.
  - S > 0: drop S LSBs.
    - Truncate: arithmetic shift right (floor).
    - Half-up: add 2^(S-1), then shift. -1.5 gives -1.
    - Convergent: as half-up, except an exact half rounds to the even result.
  - The intermediate is IW - S + 2 bits, so rounding never overflows internally.
- Stage 2, overflow:
  - Range is [-2^(OW-1), 2^(OW-1)-1]; ovf = intermediate outside that range.
  - Wrap: output the low OW bits.
  - Saturate: clamp to the max or min code by sign.
  - ovf travels with its sample through the delay line to o_ovf. o_ovf is 0 whenever o_valid=0.
- Statistics, updated when the stage-2 valid and ovf are both 1:
  - o_ovf_sticky is set.
  - o_ovf_cnt increments, holding at 2^CNTW-1.
  - Updates apply at stage 2, not at the delayed output.
- Clear rules:
  - i_clr_ovf alone: sticky=0, cnt=0 next cycle.
  - Clear coinciding with an overflow event: the event wins over the clear. sticky=1, cnt=1.
  - Reset overrides everything.
- Parameter checks: out-of-range parameters fail at elaboration via static assertion. QUAN_MODE=3 is illegal.

Decomposition:
- Package fx_match_pkg:
  - quan_mode_e (TRUNC, RND_HALF_UP, RND_CONV) and ovf_mode_e (WRAP, SAT) enums.
  - Width helper function for the intermediate width.
  - Max/min code constant functions for width W.
- Sub-module fx_delay_line: parametrised DEPTH x (WIDTH + valid + flag) shift register with synchronous active-low reset. DEPTH=0 degenerates to wires.
- Top: quantiser and overflow stages plus statistics.

Test Plan:
All cases use defaults (IW=14, IF=6, OW=12, OF=4, S=2) unless stated.
- Rounding: input 0x0006 (1.5 LSB_out) then 0x000A (2.5 LSB_out).
  - Truncate: 1, 2.
  - Half-up: 2, 3.
  - Convergent: 2, 2.
  - Each appears 2 cycles after i_valid.
- Negative half: input 0x3FFA (-1.5 LSB_out).
  - Truncate: 0xFFE.
  - Half-up: 0xFFF.
  - Convergent: 0xFFE.
- Overflow: input 0x1FFF, half-up.
  - Saturate: o_data=0x7FF, o_ovf=1.
  - Wrap: o_data=0x800, o_ovf=1.
  - Input 0x2000 gives 0x800 with o_ovf=0.
- Counter: 300 consecutive overflowing samples, CNTW=8.
  - o_ovf_cnt stops at 255; sticky=1.
  - i_clr_ovf asserted in the same cycle as a stage-2 overflow gives cnt=1, sticky=1.
- Pipeline, EXTRA_DELAY=3: a burst with i_valid gaps.
  - o_valid pattern equals the i_valid pattern shifted 5 cycles.
  - o_data holds between valids.
- Reset mid-stream: i_rst_n=0 for 1 cycle with 3 samples in flight.
  - All outputs 0 next cycle.
  - No o_valid until new input plus latency.

Source files
------------

// File: rtl/fx_match_pkg.sv
// Shared types and constant helpers for the fixed-point format matcher.
package fx_match_pkg;

   typedef enum logic [1:0] {
      TRUNC       = 2'd0,
      RND_HALF_UP = 2'd1,
      RND_CONV    = 2'd2
   } quan_mode_e;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } ovf_mode_e;

   // Quantised intermediate width: two guard bits so rounding can never wrap.
   function automatic int mid_width(int iw, int ifb, int ofb);
      return iw - (ifb - ofb) + 2;
   endfunction

   // Largest positive code of a w-bit two's-complement word.
   function automatic logic [31:0] max_code(int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Most negative code of a w-bit two's-complement word (low w bits).
   function automatic logic [31:0] min_code(int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/fx_match_pipe_if.sv
// Streaming sample interface of the format matcher.
interface fx_match_pipe_if #(
   parameter int IW   = 14,
   parameter int OW   = 12,
   parameter int CNTW = 8
);
   logic            i_valid;
   logic [IW-1:0]   i_data;
   logic            i_clr_ovf;
   logic            o_valid;
   logic [OW-1:0]   o_data;
   logic            o_ovf;
   logic            o_ovf_sticky;
   logic [CNTW-1:0] o_ovf_cnt;

   modport master (
      output i_valid, i_data, i_clr_ovf,
      input  o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt
   );

   modport slave (
      input  i_valid, i_data, i_clr_ovf,
      output o_valid, o_data, o_ovf, o_ovf_sticky, o_ovf_cnt
   );
endinterface

// File: rtl/fx_delay_line.sv
// Valid-qualified shift register; DEPTH=0 is a pass-through.
module fx_delay_line #(
   parameter int DEPTH = 0,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_flag,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_flag
);

   if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_flag  = in_flag;
   end else begin : g_regs
      logic [DEPTH-1:0] valid_q;
      logic [DEPTH-1:0] flag_q;
      logic [WIDTH-1:0] data_q [DEPTH];

      // Shift valid every cycle; data moves only with its valid, flag is cleared in gaps
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= '0;
            flag_q  <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
         end else begin
            valid_q[0] <= in_valid;
            flag_q[0]  <= in_valid & in_flag;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
               valid_q[i] <= valid_q[i-1];
               flag_q[i]  <= valid_q[i-1] & flag_q[i-1];
               if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
         end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
      assign out_flag  = flag_q[DEPTH-1];
   end

endmodule

// File: rtl/fx_match_pipe.sv
// Pipelined fixed-point format converter: quantise, overflow-handle, delay, count overflows.
module fx_match_pipe
   import fx_match_pkg::*;
#(
   parameter int IW          = 14,
   parameter int IF          = 6,
   parameter int OW          = 12,
   parameter int OF          = 4,
   parameter int QUAN_MODE   = 1,
   parameter int OVF_MODE    = 1,
   parameter int EXTRA_DELAY = 0,
   parameter int CNTW        = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   fx_match_pipe_if.slave bus
);

   localparam int S  = IF - OF;
   localparam int MW = mid_width(IW, IF, OF);
   localparam quan_mode_e QM = quan_mode_e'(2'(QUAN_MODE));
   localparam bit SAT_EN = (OVF_MODE == 1);
   localparam logic [OW-1:0] MAX_C = OW'(max_code(OW));
   localparam logic [OW-1:0] MIN_C = OW'(min_code(OW));

   if (IW < 2 || IW > 32) begin : g_bad_iw
      $error("fx_match_pipe: IW out of range");
   end
   if (OW < 2 || OW > 32) begin : g_bad_ow
      $error("fx_match_pipe: OW out of range");
   end
   if (IF < 0 || IF > IW - 1 || OF < 0 || OF > OW - 1) begin : g_bad_frac
      $error("fx_match_pipe: IF/OF out of range");
   end
   if (QUAN_MODE < 0 || QUAN_MODE > 2 || OVF_MODE < 0 || OVF_MODE > 1) begin : g_bad_mode
      $error("fx_match_pipe: illegal QUAN_MODE/OVF_MODE");
   end
   if (EXTRA_DELAY < 0 || EXTRA_DELAY > 16 || CNTW < 1) begin : g_bad_misc
      $error("fx_match_pipe: EXTRA_DELAY/CNTW out of range");
   end

   logic signed [MW-1:0] mid;

   if (S > 0) begin : g_shr
      localparam int XW = IW + 2;
      localparam logic [XW-1:0] HALF = XW'(1) << (S - 1);
      logic signed [XW-1:0] x;
      logic signed [XW-1:0] xr;
      logic                 tie;

      // Drop S LSBs; after adding a half, all-zero dropped bits mark an exact tie
      always_comb begin
         x   = {{2{bus.i_data[IW-1]}}, bus.i_data};
         xr  = x + HALF;
         tie = ~|xr[S-1:0];
         case (QM)
            TRUNC:       mid = x[XW-1:S];
            RND_HALF_UP: mid = xr[XW-1:S];
            default:     mid = xr[XW-1:S] - MW'(tie & xr[S]);
         endcase
      end
   end else begin : g_shl
      localparam int LS = -S;
      logic signed [MW-1:0] ext;
      assign ext = MW'($signed(bus.i_data));
      assign mid = ext <<< LS;
   end

   logic                 s1_valid;
   logic signed [MW-1:0] s1_mid;

   // Stage 1: register the quantised intermediate
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_mid   <= '0;
      end else begin
         s1_valid <= bus.i_valid;
         if (bus.i_valid) s1_mid <= mid;
      end
   end

   logic          ovf;
   logic [OW-1:0] wrapped;
   logic [OW-1:0] conv;

   if (MW > OW) begin : g_ovf
      logic [MW-OW:0] top;
      assign top     = s1_mid[MW-1:OW-1];
      assign ovf     = !((&top) || !(|top));
      assign wrapped = s1_mid[OW-1:0];
   end else begin : g_no_ovf
      assign ovf     = 1'b0;
      assign wrapped = OW'(s1_mid);
   end

   assign conv = (SAT_EN && ovf) ? (s1_mid[MW-1] ? MIN_C : MAX_C) : wrapped;

   logic            s2_valid;
   logic [OW-1:0]   s2_data;
   logic            s2_ovf;
   logic            sticky;
   logic [CNTW-1:0] cnt;
   logic            ovf_event;

   assign ovf_event = s1_valid & ovf;

   // Stage 2 register plus overflow statistics; an overflow outranks a same-cycle clear
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_ovf   <= 1'b0;
         sticky   <= 1'b0;
         cnt      <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_ovf   <= ovf_event;
         if (s1_valid) s2_data <= conv;
         if (ovf_event) begin
            sticky <= 1'b1;
            if (bus.i_clr_ovf)  cnt <= CNTW'(1);
            else if (cnt != '1) cnt <= cnt + CNTW'(1);
         end else if (bus.i_clr_ovf) begin
            sticky <= 1'b0;
            cnt    <= '0;
         end
      end
   end

   fx_delay_line #(
      .DEPTH (EXTRA_DELAY),
      .WIDTH (OW)
   ) u_delay (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .in_valid  (s2_valid),
      .in_data   (s2_data),
      .in_flag   (s2_ovf),
      .out_valid (bus.o_valid),
      .out_data  (bus.o_data),
      .out_flag  (bus.o_ovf)
   );

   assign bus.o_ovf_sticky = sticky;
   assign bus.o_ovf_cnt    = cnt;

endmodule

// File: tb/tb_fx_match_pipe.sv
// Directed bench: several fx_match_pipe variants share one stimulus stream.
module tb_fx_match_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld;
   logic        clr;
   logic [13:0] dat;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fx_match_pipe_if #(.IW(14), .OW(12), .CNTW(8)) bus_t ();
   fx_match_pipe_if #(.IW(14), .OW(12), .CNTW(8)) bus_h ();
   fx_match_pipe_if #(.IW(14), .OW(12), .CNTW(8)) bus_c ();
   fx_match_pipe_if #(.IW(14), .OW(12), .CNTW(8)) bus_w ();
   fx_match_pipe_if #(.IW(14), .OW(12), .CNTW(8)) bus_d ();

   assign bus_t.i_valid = vld;  assign bus_t.i_data = dat;  assign bus_t.i_clr_ovf = clr;
   assign bus_h.i_valid = vld;  assign bus_h.i_data = dat;  assign bus_h.i_clr_ovf = clr;
   assign bus_c.i_valid = vld;  assign bus_c.i_data = dat;  assign bus_c.i_clr_ovf = clr;
   assign bus_w.i_valid = vld;  assign bus_w.i_data = dat;  assign bus_w.i_clr_ovf = clr;
   assign bus_d.i_valid = vld;  assign bus_d.i_data = dat;  assign bus_d.i_clr_ovf = clr;

   fx_match_pipe #(.QUAN_MODE(0), .OVF_MODE(1)) u_t (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_t));
   fx_match_pipe #(.QUAN_MODE(1), .OVF_MODE(1)) u_h (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_h));
   fx_match_pipe #(.QUAN_MODE(2), .OVF_MODE(1)) u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_c));
   fx_match_pipe #(.QUAN_MODE(1), .OVF_MODE(0)) u_w (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_w));
   fx_match_pipe #(.QUAN_MODE(1), .OVF_MODE(1), .EXTRA_DELAY(3)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_d)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [17:0] pat;
      logic [11:0] exp_d;
      logic        exp_v;

      rst_n = 1'b0; vld = 1'b0; clr = 1'b0; dat = '0;
      tick(); tick();
      rst_n = 1'b1;
      check_eq("rst_valid",  32'(bus_h.o_valid), 0);
      check_eq("rst_data",   32'(bus_h.o_data), 0);
      check_eq("rst_ovf",    32'(bus_h.o_ovf), 0);
      check_eq("rst_sticky", 32'(bus_h.o_ovf_sticky), 0);
      check_eq("rst_cnt",    32'(bus_h.o_ovf_cnt), 0);

      // Rounding of +1.5 and +2.5 output LSBs
      vld = 1'b1; dat = 14'h0006; tick();
      dat = 14'h000A; tick();
      check_eq("r15_valid", 32'(bus_h.o_valid), 1);
      check_eq("r15_trunc", 32'(bus_t.o_data), 32'h1);
      check_eq("r15_half",  32'(bus_h.o_data), 32'h2);
      check_eq("r15_conv",  32'(bus_c.o_data), 32'h2);
      vld = 1'b0; tick();
      check_eq("r25_trunc", 32'(bus_t.o_data), 32'h2);
      check_eq("r25_half",  32'(bus_h.o_data), 32'h3);
      check_eq("r25_conv",  32'(bus_c.o_data), 32'h2);
      tick();
      check_eq("gap_valid", 32'(bus_h.o_valid), 0);
      check_eq("gap_hold",  32'(bus_h.o_data), 32'h3);
      check_eq("gap_ovf",   32'(bus_h.o_ovf), 0);

      // Negative half: -1.5 output LSBs
      vld = 1'b1; dat = 14'h3FFA; tick();
      vld = 1'b0; tick();
      check_eq("neg_trunc", 32'(bus_t.o_data), 32'hFFE);
      check_eq("neg_half",  32'(bus_h.o_data), 32'hFFF);
      check_eq("neg_conv",  32'(bus_c.o_data), 32'hFFE);

      // Overflow after rounding, then most negative input
      vld = 1'b1; dat = 14'h1FFF; tick();
      dat = 14'h2000; tick();
      check_eq("ovf_sat_data",  32'(bus_h.o_data), 32'h7FF);
      check_eq("ovf_sat_flag",  32'(bus_h.o_ovf), 1);
      check_eq("ovf_wrap_data", 32'(bus_w.o_data), 32'h800);
      check_eq("ovf_wrap_flag", 32'(bus_w.o_ovf), 1);
      check_eq("ovf_sticky_h",  32'(bus_h.o_ovf_sticky), 1);
      check_eq("trunc_no_ovf",  32'(bus_t.o_ovf_sticky), 0);
      vld = 1'b0; tick();
      check_eq("min_sat_data",  32'(bus_h.o_data), 32'h800);
      check_eq("min_sat_flag",  32'(bus_h.o_ovf), 0);
      check_eq("min_wrap_data", 32'(bus_w.o_data), 32'h800);
      check_eq("min_wrap_flag", 32'(bus_w.o_ovf), 0);
      tick();
      check_eq("cnt_one", 32'(bus_h.o_ovf_cnt), 1);
      check_eq("ovf_idle", 32'(bus_h.o_ovf), 0);

      // Clear alone
      clr = 1'b1; tick();
      clr = 1'b0;
      check_eq("clr_cnt",    32'(bus_h.o_ovf_cnt), 0);
      check_eq("clr_sticky", 32'(bus_h.o_ovf_sticky), 0);

      // 300 overflowing samples saturate the counter
      vld = 1'b1; dat = 14'h1FFF;
      for (int i = 0; i < 300; i++) tick();
      check_eq("cnt_sat",       32'(bus_h.o_ovf_cnt), 255);
      check_eq("cnt_sticky",    32'(bus_h.o_ovf_sticky), 1);
      check_eq("stream_wovf",   32'(bus_w.o_ovf), 1);
      check_eq("trunc_sticky0", 32'(bus_t.o_ovf_sticky), 0);
      clr = 1'b1; tick();
      check_eq("clr_ev_cnt",    32'(bus_h.o_ovf_cnt), 1);
      check_eq("clr_ev_sticky", 32'(bus_h.o_ovf_sticky), 1);
      clr = 1'b0; vld = 1'b0;
      for (int i = 0; i < 8; i++) tick();

      // EXTRA_DELAY=3: valid pattern shifted by 5, data holds through gaps
      pat = 18'b000000_010111001011;
      exp_d = 12'h7FF;
      for (int n = 0; n < 18; n++) begin
         exp_v = (n >= 5) ? pat[n-5] : 1'b0;
         if (exp_v) exp_d = 12'(n - 4);
         check_eq("dly_valid", 32'(bus_d.o_valid), 32'(exp_v));
         check_eq("dly_data",  32'(bus_d.o_data), 32'(exp_d));
         check_eq("dly_ovf",   32'(bus_d.o_ovf), 0);
         vld = pat[n];
         dat = 14'(4 * (n + 1));
         tick();
      end
      vld = 1'b0;

      // Reset with samples in flight
      vld = 1'b1; dat = 14'h0010; tick();
      dat = 14'h0020; tick();
      rst_n = 1'b0; dat = 14'h0030; tick();
      rst_n = 1'b1; vld = 1'b0;
      check_eq("mrst_valid",  32'(bus_h.o_valid), 0);
      check_eq("mrst_data",   32'(bus_h.o_data), 0);
      check_eq("mrst_ovf",    32'(bus_h.o_ovf), 0);
      check_eq("mrst_sticky", 32'(bus_h.o_ovf_sticky), 0);
      check_eq("mrst_cnt",    32'(bus_h.o_ovf_cnt), 0);
      check_eq("mrst_dvalid", 32'(bus_d.o_valid), 0);
      check_eq("mrst_ddata",  32'(bus_d.o_data), 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq("post_rst_h", 32'(bus_h.o_valid), 0);
         check_eq("post_rst_d", 32'(bus_d.o_valid), 0);
      end
      vld = 1'b1; dat = 14'h0014; tick();
      vld = 1'b0; tick();
      check_eq("new_h_valid", 32'(bus_h.o_valid), 1);
      check_eq("new_h_data",  32'(bus_h.o_data), 32'h5);
      tick(); tick(); tick();
      check_eq("new_d_valid", 32'(bus_d.o_valid), 1);
      check_eq("new_d_data",  32'(bus_d.o_data), 32'h5);
      tick();
      check_eq("new_d_gap",   32'(bus_d.o_valid), 0);
      check_eq("new_d_hold",  32'(bus_d.o_data), 32'h5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
